// File: rtl/wr_pattern_player.sv
// wr_pattern_player: walks a pattern ROM from START_ADDR and turns each
// 34-bit word into a config pulse, an address update or a valid/ready bus
// write. The run ends on an END word or after the word at LAST_ADDR.
// Optional build macro: WR_PATTERN_AUTOINC_EN (write address += 4 after
// every completed write).
module wr_pattern_player #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter logic [7:0] LAST_ADDR  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        EN,
  output logic [7:0]  ADDR,
  input  logic [33:0] DATA,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cfg_valid,
  output logic [7:0]  cfg_addr,
  output logic [23:0] cfg_data,
  output logic [15:0] wr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_CFG  = 2'b01;
  localparam logic [1:0] OP_SETA = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b11;

  logic [2:0]  r_state;
  logic [7:0]  r_ptr;
  logic [31:0] r_areg;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_cfg_valid;
  logic [7:0]  r_cfg_addr;
  logic [23:0] r_cfg_data;
  logic [15:0] r_wr_count;

  logic [1:0]  w_op;
  logic        w_start;
  logic        w_decode;
  logic        w_hs;
  logic        w_last;

  assign w_op     = DATA[33:32];
  // start only counts in IDLE; while busy or finishing it is dropped
  assign w_start  = (r_state == S_IDLE) && start;
  assign w_decode = (r_state == S_DECODE);
  assign w_hs     = (r_state == S_WRITE) && wr_ready;
  // the pointer never wraps: the word at LAST_ADDR is always the final one
  assign w_last   = (r_ptr == LAST_ADDR);

  // sequencer: state and ROM pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_ptr   <= START_ADDR;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_op == OP_END) begin
            r_state <= S_FINISH;
          end else if (w_op == OP_WR) begin
            r_state <= S_WRITE;
          end else if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_ptr   <= r_ptr + 8'd1;
            r_state <= S_FETCH;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            if (w_last) begin
              r_state <= S_FINISH;
            end else begin
              r_ptr   <= r_ptr + 8'd1;
              r_state <= S_FETCH;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // bus address register: cleared per run, loaded by SETA words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_areg <= 32'h0;
    end else if (w_start) begin
      r_areg <= 32'h0;
    end else if (w_decode && (w_op == OP_SETA)) begin
      r_areg <= DATA[31:0];
`ifdef WR_PATTERN_AUTOINC_EN
    end else if (w_hs) begin
      r_areg <= r_areg + 32'd4;
`endif
    end
  end

  // write beat capture: held stable for the whole WRITE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= 32'h0;
      r_wr_data <= 32'h0;
    end else if (w_decode && (w_op == OP_WR)) begin
      r_wr_addr <= r_areg;
      r_wr_data <= DATA[31:0];
    end
  end

  // config pulse: one cycle after the CFG word is decoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= 8'h00;
      r_cfg_data  <= 24'h0;
    end else begin
      r_cfg_valid <= w_decode && (w_op == OP_CFG);
      if (w_decode && (w_op == OP_CFG)) begin
        r_cfg_addr <= DATA[31:24];
        r_cfg_data <= DATA[23:0];
      end
    end
  end

  // completed-write counter, saturating, held after the run ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= 16'h0;
    end else if (w_start) begin
      r_wr_count <= 16'h0;
    end else if (w_hs && (r_wr_count != 16'hFFFF)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_WRITE);
  assign done      = (r_state == S_FINISH);
  assign EN        = (r_state == S_FETCH);
  assign ADDR      = r_ptr;
  assign wr_valid  = (r_state == S_WRITE);
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cfg_valid = r_cfg_valid;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign wr_count  = r_wr_count;

endmodule
